// File: rtl/dff_sweep_chain_pkg.sv
// ----------------------------------------------------------------------------
// dff_sweep_pkg
// Shared types and helpers for the flip-flop configuration sweep chain.
//   chan_cfg_t  : per-channel control configuration (enable/SR mapping, init)
//   cfg_decode  : maps a channel index onto its configuration code
//   CFG_CODES   : number of distinct configurations before codes repeat
// ----------------------------------------------------------------------------
package dff_sweep_pkg;

  localparam int CFG_CODES = 32;

  typedef struct packed {
    logic en_inv;  // channel shifts when en is low instead of high
    logic sr_inv;  // SR is active-low for this channel
    logic sr_val;  // value loaded into every stage on SR
    logic init;    // value of every stage while rst is high
    logic sr_src;  // 0: external sr pin, 1: internal periodic pulse
  } chan_cfg_t;

  // Code bits map one-to-one onto the struct fields, LSB = en_inv.
  function automatic chan_cfg_t cfg_decode(input int idx);
    chan_cfg_t  cfg;
    logic [4:0] code;
    code       = 5'(idx % CFG_CODES);
    cfg.en_inv = code[0];
    cfg.sr_inv = code[1];
    cfg.sr_val = code[2];
    cfg.init   = code[3];
    cfg.sr_src = code[4];
    return cfg;
  endfunction

endpackage

// File: rtl/dff_sweep_chain_if.sv
// ----------------------------------------------------------------------------
// dff_sweep_chain_if
// Stimulus/observation bundle for dff_sweep_chain.
//   d      : shared serial data into every channel
//   en     : clock enable, before per-channel inversion
//   sr     : external synchronous set/reset, before per-channel inversion
//   q      : last stage of each channel
//   pulse  : internal periodic SR pulse, for observation
// master drives d/en/sr and observes q/pulse; slave is the design side.
// ----------------------------------------------------------------------------
interface dff_sweep_chain_if #(
  parameter int WIDTH = 32
) ();

  logic             d;
  logic             en;
  logic             sr;
  logic [WIDTH-1:0] q;
  logic             pulse;

  modport master (
    output d,
    output en,
    output sr,
    input  q,
    input  pulse
  );

  modport slave (
    input  d,
    input  en,
    input  sr,
    output q,
    output pulse
  );

endinterface

// File: rtl/dff_sweep_chain_channel.sv
// ----------------------------------------------------------------------------
// dff_sweep_channel
// One DEPTH-stage shift chain with configurable enable/SR polarity.
// Priority on each rising edge: SR (load SR_VAL everywhere) > enable (shift)
// > hold. rst asynchronously loads INIT into every stage.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   d       : serial input into stage 0
//   en      : enable before EN_INV inversion
//   sr_raw  : selected SR source before SR_INV inversion
//   q       : last stage of the chain
// ----------------------------------------------------------------------------
module dff_sweep_channel #(
  parameter int DEPTH  = 4,
  parameter bit EN_INV = 1'b0,
  parameter bit SR_INV = 1'b0,
  parameter bit SR_VAL = 1'b0,
  parameter bit INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic en,
  input  logic sr_raw,
  output logic q
);

  logic [DEPTH-1:0] stage;
  logic [DEPTH-1:0] shift_next;
  logic             en_eff;
  logic             sr_eff;

  assign en_eff = en ^ EN_INV;
  assign sr_eff = sr_raw ^ SR_INV;

  // Built bitwise so DEPTH=1 needs no special-case slicing.
  always_comb begin
    shift_next    = '0;
    shift_next[0] = d;
    for (int k = 1; k < DEPTH; k++) begin
      shift_next[k] = stage[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= {DEPTH{INIT}};
    end else if (sr_eff) begin
      stage <= {DEPTH{SR_VAL}};
    end else if (en_eff) begin
      stage <= shift_next;
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/dff_sweep_chain.sv
// ----------------------------------------------------------------------------
// dff_sweep_chain
// WIDTH shift-chain channels, each with a control configuration decoded from
// its index (codes repeat every CFG_CODES channels), plus a free-running
// periodic SR pulse used as the SR source by half of the configurations.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of dff_sweep_chain_if (d, en, sr in; q, pulse out)
// Parameters: WIDTH channels, DEPTH stages per channel, PULSE_PERIOD cycles
// between internal SR pulses (>=2).
// ----------------------------------------------------------------------------
module dff_sweep_chain
  import dff_sweep_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter int PULSE_PERIOD = 8
) (
  input  logic             clk,
  input  logic             rst,
  dff_sweep_chain_if.slave bus
);

  localparam int                CNT_W    = (PULSE_PERIOD > 1) ? $clog2(PULSE_PERIOD) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PULSE_PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic             pulse_q;
  logic [WIDTH-1:0] q_int;

  // pulse is high for the single cycle after the counter sits at its last
  // value, so the first pulse appears PULSE_PERIOD edges after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= (cnt == CNT_LAST);
      if (cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    localparam chan_cfg_t CFG = cfg_decode(i);

    logic sr_raw;

    assign sr_raw = CFG.sr_src ? pulse_q : bus.sr;

    dff_sweep_channel #(
      .DEPTH  (DEPTH),
      .EN_INV (CFG.en_inv),
      .SR_INV (CFG.sr_inv),
      .SR_VAL (CFG.sr_val),
      .INIT   (CFG.init)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .d      (bus.d),
      .en     (bus.en),
      .sr_raw (sr_raw),
      .q      (q_int[i])
    );
  end

  assign bus.q     = q_int;
  assign bus.pulse = pulse_q;

endmodule

// File: tb/tb_dff_sweep_chain.sv
// ----------------------------------------------------------------------------
// tb_dff_sweep_chain
// Directed bench for dff_sweep_chain (DEPTH=4, PULSE_PERIOD=8). A 32-channel
// and a 40-channel instance share all stimulus; channels 32..39 of the wide
// instance are held to the same expected values as channels 0..7.
// ----------------------------------------------------------------------------
module tb_dff_sweep_chain;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic d   = 1'b0;
  logic en  = 1'b0;
  logic sr  = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int edge_n      = 0;

  always #5 clk = ~clk;

  dff_sweep_chain_if #(.WIDTH(32)) bus32 ();
  dff_sweep_chain_if #(.WIDTH(40)) bus40 ();

  assign bus32.d  = d;
  assign bus32.en = en;
  assign bus32.sr = sr;
  assign bus40.d  = d;
  assign bus40.en = en;
  assign bus40.sr = sr;

  dff_sweep_chain #(.WIDTH(32), .DEPTH(4), .PULSE_PERIOD(8)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  dff_sweep_chain #(.WIDTH(40), .DEPTH(4), .PULSE_PERIOD(8)) dut40 (
    .clk (clk),
    .rst (rst),
    .bus (bus40)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [31:0] exp);
    chk(tag, bus32.q, exp);
    chk($sformatf("%s_w40_lo", tag), bus40.q[31:0], exp);
    chk($sformatf("%s_w40_hi", tag), {24'h0, bus40.q[39:32]}, {24'h0, exp[7:0]});
  endtask

  // One rising edge; pulse is expected only after every 8th edge since release.
  task automatic step();
    logic pulse_exp;
    @(posedge clk);
    #1;
    if (!rst) edge_n++;
    pulse_exp = !rst && (edge_n != 0) && (edge_n % 8 == 0);
    chk($sformatf("pulse_e%0d", edge_n), {31'h0, bus32.pulse}, {31'h0, pulse_exp});
    chk($sformatf("pulse40_e%0d", edge_n), {31'h0, bus40.pulse}, {31'h0, pulse_exp});
  endtask

  initial begin
    // Reset takes effect with no clock edge.
    #1 rst = 1'b1;
    #1;
    chk_q("reset_async", 32'hFF00FF00);
    chk("reset_pulse", {31'h0, bus32.pulse}, 32'h0);

    step();
    step();
    chk_q("reset_held", 32'hFF00FF00);

    rst = 1'b0;
    edge_n = 0;
    sr = 1'b0; en = 1'b1; d = 1'b1;
    chk_q("release_no_edge", 32'hFF00FF00);

    // Shift ones: plain channels see d at q only after the 4th edge.
    for (int e = 1; e <= 3; e++) begin
      step();
      chk_q($sformatf("shift1_e%0d", e), 32'hF3C0F3C0);
    end
    step();
    chk_q("shift1_e4", 32'hF3D1F3D1);

    // External SR beats enable.
    en = 1'b1; d = 1'b0; sr = 1'b1;
    step();
    chk_q("sr_priority", 32'hF3D1F0F0);

    // Free-run: internal-pulse channels with active-high SR load sr_val on
    // the edge ending each pulse-high cycle; channel 18 stays at 0.
    sr = 1'b0; en = 1'b1; d = 1'b1;
    for (int e = 6; e <= 25; e++) begin
      step();
      chk($sformatf("q18_e%0d", edge_n), {31'h0, bus32.q[18]}, 32'h0);
      if (edge_n == 8)
        chk("pulse_sr_e8", {16'h0, bus32.q[31:16] & 16'h3333}, 32'h0000_2200);
      if (edge_n == 9)
        chk("pulse_sr_e9", {16'h0, bus32.q[31:16] & 16'h3333}, 32'h0000_3030);
      if (edge_n == 16)
        chk("pulse_sr_e16", {16'h0, bus32.q[31:16] & 16'h3333}, 32'h0000_3131);
      if (edge_n == 17)
        chk("pulse_sr_e17", {16'h0, bus32.q[31:16] & 16'h3333}, 32'h0000_3030);
    end

    // Shift 1,0,1,1 then reset between edges.
    d = 1'b1; step();
    d = 1'b0; step();
    d = 1'b1; step();
    d = 1'b1; step();
    #3 rst = 1'b1;
    #1;
    edge_n = 0;
    chk_q("midshift_rst", 32'hFF00FF00);
    chk("midshift_pulse", {31'h0, bus32.pulse}, 32'h0);
    step();
    step();
    chk_q("midshift_held", 32'hFF00FF00);

    rst = 1'b0;
    en = 1'b1; d = 1'b0; sr = 1'b0;
    step();
    chk_q("rerelease_e1", 32'hF3C0F3C0);
    for (int e = 2; e <= 10; e++) begin
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
